tlb_op_ctrl: RTL
================

TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

Interface
REQ-001 SHALL have parameter TLBIDLEN, default 4, meaning TLB index width (2^TLBIDLEN entries).
REQ-002 SHALL have port clk  input  1  clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset; clock is clk.
REQ-004 SHALL have ports op_valid  input  1 and op_ready  output  1: TLB-instruction request handshake.
REQ-005 SHALL have ports op_code  input  3 (0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV), op_inv  input  5, op_asid  input  10, op_va  input  32, op_index  input  TLBIDLEN.
REQ-006 SHALL have ports srch_valid  output  1, srch_ok  input  1, srch_found  input  1, srch_index  input  TLBIDLEN: shared lookup port.
REQ-007 SHALL have ports we  output  1, w_index  output  TLBIDLEN, r_index  output  TLBIDLEN.
REQ-008 SHALL have ports invtlb_valid  output  1, invtlb_op  output  5, invtlb_asid  output  10, invtlb_va  output  32.
REQ-009 SHALL have ports done  output  1, done_found  output  1, done_index  output  TLBIDLEN, done_err  output  1.

Function
REQ-010 SHALL implement FSM states IDLE, SRCH, ISSUE, SETTLE; op_ready = 1 only in IDLE.
REQ-011 SHALL latch op_code/op_inv/op_asid/op_va/op_index on op_valid & op_ready.
REQ-012 On accept: SRCH -> state SRCH; RD/WR/FILL/INV -> ISSUE; op_code 5-7 -> stay IDLE, done=1 and done_err=1 next cycle.
REQ-013 In SRCH: srch_valid=1 every cycle until srch_ok=1; that cycle latch srch_found/srch_index, then go IDLE with done=1, done_found/done_index driven that cycle.
REQ-014 ISSUE lasts exactly one cycle: WR -> we=1, w_index=latched op_index; FILL -> we=1, w_index=fill pointer; RD -> r_index=latched op_index; INV -> invtlb_valid=1, invtlb_op/asid/va from latch.
REQ-015 SETTLE lasts exactly one cycle (covers the tcache refill register stage), then IDLE with done=1 and done_found=0.
REQ-016 Latency accept->done: RD/WR/FILL/INV 3 cycles; SRCH 2 + srch_ok wait cycles; invalid opcode 1 cycle.
REQ-017 done, we, invtlb_valid, srch_valid SHALL be single-cycle pulses except srch_valid as in REQ-013; never two ops overlap.
REQ-018 r_index SHALL hold the last RD index outside ISSUE (entry readable combinationally after done).
REQ-019 Fill pointer SHALL advance by one step on every FILL ISSUE cycle only, wrapping modulo 2^TLBIDLEN.
REQ-020 INV with op_inv > 6 SHALL skip invtlb_valid, go to SETTLE, then done with done_err=1.
REQ-021 op_valid while not ready SHALL be ignored; request held by upstream.

Reset
REQ-022 On reset: state IDLE, op_ready=1 from the following cycle, all strobes 0, done/done_err/done_found 0, done_index 0, r_index 0, w_index 0, fill pointer to its seed.
REQ-023 Reset mid-operation SHALL abort with no we/invtlb_valid/done issued that cycle or after.

Configuration
REQ-024 Macro TLB_FILL_LFSR_EN defined: fill pointer is low TLBIDLEN bits of an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), seed 8'h01, stepping per REQ-019.
REQ-025 Macro TLB_FILL_LFSR_EN undefined: fill pointer is a TLBIDLEN-bit round-robin counter, seed 0, incrementing per REQ-019.

Verification
REQ-026 WR op_index=5 -> one cycle we=1, w_index=5; done 3 cycles after accept, done_err=0.
REQ-027 SRCH, srch_ok after 3 cycles with found=1 index=9 -> srch_valid high 3 cycles, done with done_found=1, done_index=9.
REQ-028 Undefined macro: 17 consecutive FILLs (16 entries) -> w_index 0,1,...,15,0.
REQ-029 INV op_inv=2, asid=0x3A -> invtlb_valid one cycle, invtlb_op=2, invtlb_asid=0x3A; op_inv=7 -> no invtlb_valid, done_err=1.
REQ-030 Reset asserted during SRCH wait -> srch_valid 0 next cycle, no done, op_ready=1 after reset release.
REQ-031 op_code=6 -> done=1, done_err=1 one cycle after accept, no strobes.

Source files
------------

// File: rtl/tlb_op_ctrl.sv
// TLB instruction sequencer: SRCH/RD/WR/FILL/INV over a shared lookup port.
// Define TLB_FILL_LFSR_EN for an LFSR fill pointer; default is a round-robin counter.
module tlb_op_ctrl #(
  parameter int unsigned TLBIDLEN = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [2:0]          op_code,
  input  logic [4:0]          op_inv,
  input  logic [9:0]          op_asid,
  input  logic [31:0]         op_va,
  input  logic [TLBIDLEN-1:0] op_index,
  output logic                srch_valid,
  input  logic                srch_ok,
  input  logic                srch_found,
  input  logic [TLBIDLEN-1:0] srch_index,
  output logic                we,
  output logic [TLBIDLEN-1:0] w_index,
  output logic [TLBIDLEN-1:0] r_index,
  output logic                invtlb_valid,
  output logic [4:0]          invtlb_op,
  output logic [9:0]          invtlb_asid,
  output logic [31:0]         invtlb_va,
  output logic                done,
  output logic                done_found,
  output logic [TLBIDLEN-1:0] done_index,
  output logic                done_err
);

  typedef enum logic [1:0] {IDLE, SRCH, ISSUE, SETTLE} state_e;
  typedef enum logic [2:0] {OP_SRCH, OP_RD, OP_WR, OP_FILL, OP_INV} op_e;

  state_e              state_q;
  logic [2:0]          op_code_q;
  logic [4:0]          op_inv_q;
  logic [9:0]          op_asid_q;
  logic [31:0]         op_va_q;
  logic                srch_valid_q, we_q, invtlb_valid_q;
  logic                done_q, done_found_q, done_err_q;
  logic [TLBIDLEN-1:0] done_index_q, w_index_q, r_index_q;
  logic [TLBIDLEN-1:0] fill_ptr;
  logic                fill_step;

  assign fill_step = (state_q == ISSUE) && (op_code_q == OP_FILL);

`ifdef TLB_FILL_LFSR_EN
  logic [7:0] lfsr_q;
  assign fill_ptr = TLBIDLEN'(lfsr_q);
  always_ff @(posedge clk) begin
    if (reset)          lfsr_q <= 8'h01;
    else if (fill_step) lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end
`else
  logic [TLBIDLEN-1:0] rr_q;
  assign fill_ptr = rr_q;
  always_ff @(posedge clk) begin
    if (reset)          rr_q <= '0;
    else if (fill_step) rr_q <= rr_q + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      op_code_q      <= '0;
      op_inv_q       <= '0;
      op_asid_q      <= '0;
      op_va_q        <= '0;
      srch_valid_q   <= 1'b0;
      we_q           <= 1'b0;
      invtlb_valid_q <= 1'b0;
      done_q         <= 1'b0;
      done_found_q   <= 1'b0;
      done_err_q     <= 1'b0;
      done_index_q   <= '0;
      w_index_q      <= '0;
      r_index_q      <= '0;
    end else begin
      we_q           <= 1'b0;
      invtlb_valid_q <= 1'b0;
      done_q         <= 1'b0;
      done_found_q   <= 1'b0;
      done_err_q     <= 1'b0;
      case (state_q)
        IDLE: if (op_valid) begin
          op_code_q <= op_code;
          op_inv_q  <= op_inv;
          op_asid_q <= op_asid;
          op_va_q   <= op_va;
          // Strobes are set on accept so they are registered during the ISSUE cycle.
          case (op_code)
            OP_SRCH: begin state_q <= SRCH;  srch_valid_q <= 1'b1; end
            OP_RD:   begin state_q <= ISSUE; r_index_q <= op_index; end
            OP_WR:   begin state_q <= ISSUE; we_q <= 1'b1; w_index_q <= op_index; end
            OP_FILL: begin state_q <= ISSUE; we_q <= 1'b1; w_index_q <= fill_ptr; end
            OP_INV:  begin state_q <= ISSUE; invtlb_valid_q <= (op_inv <= 5'd6); end
            default: begin done_q <= 1'b1; done_err_q <= 1'b1; done_index_q <= '0; end
          endcase
        end
        SRCH: if (srch_ok) begin
          state_q      <= IDLE;
          srch_valid_q <= 1'b0;
          done_q       <= 1'b1;
          done_found_q <= srch_found;
          done_index_q <= srch_index;
        end
        ISSUE: state_q <= SETTLE;
        SETTLE: begin
          state_q      <= IDLE;
          done_q       <= 1'b1;
          done_err_q   <= (op_code_q == OP_INV) && (op_inv_q > 5'd6);
          done_index_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes are masked by reset so an abort suppresses them in the reset cycle itself.
  assign op_ready     = (state_q == IDLE);
  assign srch_valid   = srch_valid_q & ~reset;
  assign we           = we_q & ~reset;
  assign invtlb_valid = invtlb_valid_q & ~reset;
  assign done         = done_q & ~reset;
  assign done_found   = done_found_q;
  assign done_err     = done_err_q;
  assign done_index   = done_index_q;
  assign w_index      = w_index_q;
  assign r_index      = r_index_q;
  assign invtlb_op    = op_inv_q;
  assign invtlb_asid  = op_asid_q;
  assign invtlb_va    = op_va_q;

endmodule
